// File: rtl/red_pitaya_asg_trig_cond.sv
// ASG trigger conditioner: synchronizes, debounces and edge-selects the external trigger,
// merges the software trigger, then applies delay and holdoff before emitting one pulse.
module red_pitaya_asg_trig_cond #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DBW         = 20,
   parameter int unsigned CW          = 32,
   parameter int unsigned MW          = 16
) (
   input  logic           dac_clk_i,
   input  logic           dac_rstn_i,
   input  logic           trig_ext_i,
   input  logic           trig_sw_i,
   input  logic           cfg_en_i,
   input  logic           cfg_edge_i,
   input  logic [DBW-1:0] cfg_deb_i,
   input  logic [CW-1:0]  cfg_dly_i,
   input  logic [CW-1:0]  cfg_hold_i,
   input  logic           miss_clr_i,
   output logic           trig_o,
   output logic           busy_o,
   output logic           lvl_o,
   output logic [MW-1:0]  miss_cnt_o
);

   typedef enum logic [1:0] {IDLE, DELAY, HOLD} state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [DBW-1:0]         r_deb_cnt;
   logic                   r_lvl;
   logic                   r_lvl_d;
   logic                   r_sw;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_trig;
   logic [MW-1:0]          r_miss;

   logic                   w_s;
   logic                   w_edge;
   logic                   w_event;
   logic                   w_miss_inc;

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_edge     = cfg_edge_i ? (r_lvl_d & ~r_lvl) : (r_lvl & ~r_lvl_d);
   // Software trigger is registered once so both paths meet the same event stage.
   assign w_event    = cfg_en_i & (w_edge | r_sw);
   assign w_miss_inc = w_event & (r_state != IDLE);

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         r_sync    <= '0;
         r_deb_cnt <= '0;
         r_lvl     <= 1'b0;
         r_lvl_d   <= 1'b0;
         r_sw      <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], trig_ext_i};
         r_lvl_d <= r_lvl;
         r_sw    <= trig_sw_i;
         if (w_s != r_lvl) begin
            // >= keeps a shortened cfg_deb_i from stranding a running count.
            if (r_deb_cnt >= cfg_deb_i) begin
               r_lvl     <= w_s;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + DBW'(1);
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_trig  <= 1'b0;
      end else if (!cfg_en_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_trig  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_trig <= 1'b0;
               if (w_event) begin
                  r_cnt   <= cfg_dly_i;
                  r_state <= DELAY;
               end
            end
            DELAY: begin
               if (r_cnt == '0) begin
                  r_trig  <= 1'b1;
                  r_cnt   <= cfg_hold_i;
                  r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            HOLD: begin
               r_trig <= 1'b0;
               if (r_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_trig  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         r_miss <= '0;
      end else if (miss_clr_i) begin
         r_miss <= '0;
      end else if (w_miss_inc && (r_miss != '1)) begin
         r_miss <= r_miss + MW'(1);
      end
   end

   assign trig_o     = r_trig;
   assign busy_o     = (r_state != IDLE);
   assign lvl_o      = r_lvl;
   assign miss_cnt_o = r_miss;

endmodule
